// File: rtl/rv_ifu_fetch.sv
// rv_ifu_fetch: PC owner and single-outstanding instruction fetch feeding the IF->ID handshake.
// Defining IFU_PERF_CNT_EN adds saturating perf_fetch_cnt / perf_stall_cnt outputs.
module rv_ifu_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [WIDTH-1:0]   imem_resp_data,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               halt,
    output logic               IF_ID_valid,
    input  logic               IF_ID_ready,
    output logic [2*WIDTH-1:0] IF_ID_message
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d, req_pc_q, req_pc_d, redir_pc;
    logic               kill_q, kill_d, valid_q, valid_d, req_fire, deliver;
    logic [2*WIDTH-1:0] msg_q, msg_d;

    assign redir_pc       = {redirect_pc[WIDTH-1:2], 2'b00};
    assign imem_req_valid = (state_q == S_REQ) & ~halt & ~redirect_valid & (~valid_q | IF_ID_ready);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign deliver        = (state_q == S_WAIT) & imem_resp_valid & ~kill_q & ~redirect_valid;
    assign IF_ID_valid    = valid_q;
    assign IF_ID_message  = msg_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        valid_d  = valid_q & ~IF_ID_ready;
        msg_d    = msg_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                pc_d    = redirect_valid ? redir_pc : pc_q;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end else if (req_fire) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response always closes the outstanding request; kill only decides whether it is kept.
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    pc_d    = redirect_valid ? redir_pc : (kill_q ? pc_q : req_pc_q + WIDTH'(4));
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redir_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (deliver) begin
            valid_d = 1'b1;
            msg_d   = {req_pc_q, imem_resp_data};
        end
        if (redirect_valid) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
            msg_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
            valid_q  <= valid_d;
            msg_q    <= msg_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = (valid_q & IF_ID_ready & !(&fetch_cnt_q)) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        stall_cnt_d = ((state_q == S_WAIT) & !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule
